// File: rtl/serial_frame_rx_ctrl.sv
// Serial frame receive controller: start detect, shift sequencing,
// stop-bit check, word latch with valid/ack and good-frame count.
module serial_frame_rx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sIn,
  input  logic [DATA_BITS-1:0] par_in,
  output logic                 shift_en,
  output logic                 sr_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int BW =
    (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

  logic [1:0]    state;
  logic [BW-1:0] bit_cnt;

  // Shift-register controls follow the state directly.
  always_comb begin
    shift_en = (state == SHIFT);
    sr_clr   = (state == IDLE);
  end

  // Frame sequencing, word latch, error pulse and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (sIn) state <= SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (!sIn) begin
            data_out   <= par_in;
            data_valid <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
            state      <= HOLD;
          end else begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
        end
        HOLD: begin
          if (data_ack) begin
            data_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
// Self-checking bench for serial_frame_rx_ctrl with a behavioural
// shift register and a frame-level reference model.
module tb_serial_frame_rx_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sIn = 1'b0;
  logic [DW-1:0] par_in;
  logic          shift_en;
  logic          sr_clr;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ack = 1'b0;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_data;
  logic [CW-1:0] ref_cnt;

  serial_frame_rx_ctrl #(
    .DATA_BITS(DW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sIn(sIn),
    .par_in(par_in),
    .shift_en(shift_en),
    .sr_clr(sr_clr),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ack(data_ack),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sr = '0;
  always @(posedge clk) begin
    if (sr_clr) sr <= '0;
    else if (shift_en) sr <= {sr[DW-2:0], sIn};
  end
  assign par_in = sr;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] w,
                            input logic stop);
    sIn = 1'b1;
    tick();
    for (int i = DW - 1; i >= 0; i--) begin
      checks++;
      if (shift_en !== 1'b1 || sr_clr !== 1'b0) begin
        errors++;
        $display("FAIL shift_win bit %0d got en=%b clr=%b exp en=1 clr=0",
                 i, shift_en, sr_clr);
      end
      sIn = w[i];
      tick();
    end
    checks++;
    if (shift_en !== 1'b0) begin
      errors++;
      $display("FAIL shift_count got en=%b exp 0 after %0d bits",
               shift_en, DW);
    end
    sIn = stop;
    tick();
    sIn = 1'b0;
    if (!stop) begin
      ref_data = w;
      ref_cnt  = ref_cnt + 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_ack = 1'b0;
    sIn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ref_data = '0;
    ref_cnt  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (shift_en !== 1'b0 || sr_clr !== 1'b1 ||
          data_valid !== 1'b0 || frame_cnt !== '0 ||
          data_out !== '0 || frame_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got en=%b clr=%b v=%b cnt=%h d=%h e=%b exp 0 1 0 00 00 0",
                 i, shift_en, sr_clr, data_valid, frame_cnt,
                 data_out, frame_err);
      end
      tick();
    end
  endtask

  task automatic test_good_frame();
    send_frame(8'hB2, 1'b0);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'hB2 ||
        frame_cnt !== 8'd1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL good_frame got v=%b d=%h cnt=%h e=%b exp 1 b2 01 0",
               data_valid, data_out, frame_cnt, frame_err);
    end
    for (int i = 0; i < 20; i++) begin
      sIn = 1'($urandom);
      tick();
      checks++;
      if (data_valid !== 1'b1 || data_out !== 8'hB2 ||
          frame_cnt !== 8'd1 || shift_en !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d got v=%b d=%h cnt=%h en=%b exp 1 b2 01 0",
                 i, data_valid, data_out, frame_cnt, shift_en);
      end
    end
    sIn = 1'b0;
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || sr_clr !== 1'b1) begin
      errors++;
      $display("FAIL ack got v=%b clr=%b exp 0 1",
               data_valid, sr_clr);
    end
  endtask

  task automatic test_frame_err();
    logic [DW-1:0] d0;
    logic [CW-1:0] c0;
    d0 = ref_data;
    c0 = ref_cnt;
    send_frame(8'hFF, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || data_valid !== 1'b0 ||
        data_out !== d0 || frame_cnt !== c0 || sr_clr !== 1'b1) begin
      errors++;
      $display("FAIL ferr_pulse got e=%b v=%b d=%h cnt=%h clr=%b exp 1 0 %h %h 1",
               frame_err, data_valid, data_out, frame_cnt, sr_clr,
               d0, c0);
    end
    tick();
    checks++;
    if (frame_err !== 1'b0 || frame_cnt !== c0) begin
      errors++;
      $display("FAIL ferr_width got e=%b cnt=%h exp 0 %h",
               frame_err, frame_cnt, c0);
    end
  endtask

  task automatic test_mid_reset();
    sIn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sIn = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sIn = 1'b0;
    ref_data = '0;
    ref_cnt  = '0;
    checks++;
    if (shift_en !== 1'b0 || sr_clr !== 1'b1 ||
        frame_cnt !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL mid_reset got en=%b clr=%b cnt=%h d=%h exp 0 1 00 00",
               shift_en, sr_clr, frame_cnt, data_out);
    end
    tick();
    send_frame(8'h5A, 1'b0);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h5A ||
        frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL after_reset got v=%b d=%h cnt=%h exp 1 5a 01",
               data_valid, data_out, frame_cnt);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h3C, 1'b0);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_first got v=%b d=%h exp 1 3c",
               data_valid, data_out);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    send_frame(8'hC3, 1'b0);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'hC3 ||
        frame_cnt !== 8'd2) begin
      errors++;
      $display("FAIL b2b_second got v=%b d=%h cnt=%h exp 1 c3 02",
               data_valid, data_out, frame_cnt);
    end
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    logic          bad;
    int            gap;
    logic [DW-1:0] d0;
    logic [CW-1:0] c0;
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        data_ack = 1'($urandom);
        tick();
      end
      data_ack = 1'b0;
      w   = DW'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      d0  = ref_data;
      c0  = ref_cnt;
      send_frame(w, bad);
      checks++;
      if (frame_err !== bad || data_valid !== !bad ||
          data_out !== (bad ? d0 : w) ||
          frame_cnt !== (bad ? c0 : c0 + 1'b1)) begin
        errors++;
        $display("FAIL rand_frame %0d got e=%b v=%b d=%h cnt=%h exp %b %b %h %h",
                 n, frame_err, data_valid, data_out, frame_cnt,
                 bad, !bad, bad ? d0 : w, bad ? c0 : c0 + 1'b1);
      end
      if (!bad) begin
        gap = $urandom_range(0, 4);
        for (int g = 0; g < gap; g++) begin
          sIn = 1'($urandom);
          tick();
        end
        sIn = 1'b0;
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        checks++;
        if (data_valid !== 1'b0 || data_out !== w) begin
          errors++;
          $display("FAIL rand_ack %0d got v=%b d=%h exp 0 %h",
                   n, data_valid, data_out, w);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] w;
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      w = DW'($urandom);
      send_frame(w, 1'b0);
      checks++;
      if (frame_cnt !== ref_cnt || data_out !== w) begin
        errors++;
        $display("FAIL wrap_frame %0d got cnt=%h d=%h exp %h %h",
                 i, frame_cnt, data_out, ref_cnt, w);
      end
      if (i >= 256) begin
        checks++;
        if (frame_cnt !== CW'(i - 256)) begin
          errors++;
          $display("FAIL wrap_point %0d got cnt=%h exp %h",
                   i, frame_cnt, CW'(i - 256));
        end
      end
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_err();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
